// File: rtl/d_lock_pkg.sv
// Shared types and constants for the digital-lock timer controller.
package d_lock_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ENTRY   = 2'd1,
      LOCKOUT = 2'd2
   } lock_state_t;

   // Colour encoding: bit [2]=R, [1]=G, [0]=B
   localparam logic [2:0] RGB_GREEN = 3'b010;
   localparam logic [2:0] RGB_BLUE  = 3'b001;
   localparam logic [2:0] RGB_RED   = 3'b100;
   localparam logic [2:0] RGB_OFF   = 3'b000;

endpackage

// File: rtl/d_rgb_blink.sv
// RGB status driver: shows the colour solid, or blinks it against OFF with a
// BLINK_DIV-cycle half-period while blink_en is high. The inputs are the
// next-cycle values from the controller, so the registered output lines up
// with the controller's registered state.
module d_rgb_blink
   import d_lock_pkg::*;
#(
   parameter int BLINK_DIV = 31_250_000
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic [2:0] colour,
   input  logic       blink_en,
   output logic [2:0] rgb_out
);

   localparam int CNT_W = $clog2(BLINK_DIV + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;
   logic             en_q, en_d;
   logic [2:0]       rgb_q, rgb_d;

   // Half-period counter and phase; a rising blink_en restarts with colour shown
   always_comb begin
      cnt_d   = '0;
      phase_d = 1'b0;
      en_d    = blink_en;
      if (blink_en && en_q) begin
         if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d   = cnt_q + 1'b1;
            phase_d = phase_q;
         end
      end
      rgb_d = phase_d ? RGB_OFF : colour;
   end

   // Blink state and registered colour output
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
         en_q    <= 1'b0;
         rgb_q   <= RGB_GREEN;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         en_q    <= en_d;
         rgb_q   <= rgb_d;
      end
   end

   assign rgb_out = rgb_q;

endmodule

// File: rtl/d_lock_timer_ctrl.sv
// Lock-timer controller: entry-window countdown, escalating lockout timer,
// LED thermometer bar and RGB status. Every output is registered from the
// next-state values so a state change and its outputs appear together.
module d_lock_timer_ctrl
   import d_lock_pkg::*;
#(
   parameter int TICK_DIV  = 125_000_000,
   parameter int BLINK_DIV = 31_250_000,
   parameter int LED_W     = 10,
   parameter int ERR_W     = 3,
   parameter int MAX_ERR   = 3,
   parameter int LOCK_BASE = 10,
   parameter int LOCK_MAX  = 80
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             enb_cnt,
   input  logic             ignore,
   input  logic             gen_stop,
   input  logic [ERR_W-1:0] error_counter,
   output logic             enb_set,
   output logic             enb_inp,
   output logic             sys_clr,
   output logic [LED_W-1:0] led_cnt,
   output logic [2:0]       rgb_out
);

   localparam int REM_MAX = (LOCK_MAX > LED_W) ? LOCK_MAX : LED_W;
   localparam int REM_W   = $clog2(REM_MAX + 1);
   localparam int PRE_W   = $clog2(TICK_DIV + 1);
   localparam int DUR0    = (LOCK_BASE < LOCK_MAX) ? LOCK_BASE : LOCK_MAX;

   lock_state_t      state_q, state_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             sys_clr_q, sys_clr_d;
   logic             enb_set_q, enb_set_d;
   logic             enb_inp_q, enb_inp_d;
   logic [LED_W-1:0] led_cnt_q, led_cnt_d;

   logic [REM_W:0]   dur_acc;
   logic [ERR_W-1:0] err_exc;
   logic             err_hit;
   logic             tick;
   logic [2:0]       colour;
   logic             blink_en;

   // Lockout length: base doubled once per excess error, clamped after each
   // doubling. The accumulator never exceeds LOCK_MAX before a doubling, so one
   // spare bit is enough to hold the doubled value without overflow.
   always_comb begin
      err_hit = (error_counter >= ERR_W'(MAX_ERR));
      err_exc = error_counter - ERR_W'(MAX_ERR);
      dur_acc = (REM_W + 1)'(DUR0);
      for (int i = 0; i < (1 << ERR_W); i++) begin
         if (ERR_W'(i) < err_exc) begin
            dur_acc = {dur_acc[REM_W-1:0], 1'b0};
            if (dur_acc > (REM_W + 1)'(LOCK_MAX))
               dur_acc = (REM_W + 1)'(LOCK_MAX);
         end
      end
   end

   assign tick = (pre_q == PRE_W'(TICK_DIV - 1));

   // Next-state, countdown and prescaler; the prescaler is cleared on every entry
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      pre_d     = pre_q;
      sys_clr_d = 1'b0;
      case (state_q)
         IDLE: begin
            rem_d = '0;
            pre_d = '0;
            if (enb_cnt) begin
               state_d = ENTRY;
               rem_d   = REM_W'(LED_W);
            end
         end
         ENTRY: begin
            if (gen_stop) begin
               state_d = IDLE;
               rem_d   = '0;
               pre_d   = '0;
            end else if (err_hit) begin
               state_d = LOCKOUT;
               rem_d   = dur_acc[REM_W-1:0];
               pre_d   = '0;
            end else if (ignore) begin
               pre_d = pre_q;
            end else if (tick) begin
               pre_d = '0;
               if (rem_q == REM_W'(1)) begin
                  state_d   = IDLE;
                  rem_d     = '0;
                  sys_clr_d = 1'b1;
               end else begin
                  rem_d = rem_q - 1'b1;
               end
            end else begin
               pre_d = pre_q + 1'b1;
            end
         end
         LOCKOUT: begin
            if (tick) begin
               pre_d = '0;
               if (rem_q == REM_W'(1)) begin
                  state_d   = IDLE;
                  rem_d     = '0;
                  sys_clr_d = 1'b1;
               end else begin
                  rem_d = rem_q - 1'b1;
               end
            end else begin
               pre_d = pre_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            rem_d   = '0;
            pre_d   = '0;
         end
      endcase
   end

   // Output decode from next-state values; LED bar is a thermometer of rem
   always_comb begin
      enb_set_d = (state_d == IDLE);
      enb_inp_d = (state_d != LOCKOUT);
      blink_en  = (state_d == LOCKOUT);
      case (state_d)
         ENTRY:   colour = RGB_BLUE;
         LOCKOUT: colour = RGB_RED;
         default: colour = RGB_GREEN;
      endcase
      led_cnt_d = '0;
      for (int i = 0; i < LED_W; i++)
         led_cnt_d[i] = (rem_d > REM_W'(i));
   end

   // State, counters and registered outputs
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         rem_q     <= '0;
         pre_q     <= '0;
         sys_clr_q <= 1'b0;
         enb_set_q <= 1'b1;
         enb_inp_q <= 1'b1;
         led_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         pre_q     <= pre_d;
         sys_clr_q <= sys_clr_d;
         enb_set_q <= enb_set_d;
         enb_inp_q <= enb_inp_d;
         led_cnt_q <= led_cnt_d;
      end
   end

   d_rgb_blink #(
      .BLINK_DIV (BLINK_DIV)
   ) u_blink (
      .clk_in   (clk_in),
      .reset    (reset),
      .colour   (colour),
      .blink_en (blink_en),
      .rgb_out  (rgb_out)
   );

   assign enb_set = enb_set_q;
   assign enb_inp = enb_inp_q;
   assign sys_clr = sys_clr_q;
   assign led_cnt = led_cnt_q;

endmodule
